life_array_grid: RTL and testbench

// - Parametrised ROWS x COLS tile of Conway Life cells (B3/S23), one register per cell.
// - Loads a pattern in parallel.
// - Advances one generation per step rising edge, or periodically in free-run mode.
// - Exposes boundary neighbour inputs so tiles can be stitched into larger boards.
// - Adds a generation counter plus changed/extinct status for the display/scan controller.

---
 rtl/life_array_grid.sv | 143 ++++++++++++++
 tb/tb_life_array_grid.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/life_array_grid.sv
// ROWS x COLS Conway Life (B3/S23) tile with parallel load, step/free-run advance and status outputs.
// Define LIFE_TORUS_EN to wrap the tile toroidally instead of using the boundary neighbour inputs.
module life_array_grid #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int GEN_W  = 16,
    parameter int PERIOD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] val,
    input  logic                 write_enb,
    input  logic                 step,
    input  logic                 run,
    input  logic [COLS-1:0]      n,
    input  logic [COLS-1:0]      s,
    input  logic [ROWS-1:0]      w,
    input  logic [ROWS-1:0]      e,
    input  logic                 nw,
    input  logic                 ne,
    input  logic                 sw,
    input  logic                 se,
    output logic [ROWS*COLS-1:0] alive,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 changed,
    output logic                 extinct
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int N     = ROWS * COLS;

    logic             step_q;
    logic [CNT_W-1:0] per_cnt;
    logic             step_req;
    logic             run_req;
    logic             adv;
    logic [N-1:0]     nxt;

    // Halo-padded copy of the tile: ext[r+1][c+1] is cell (r,c).
    logic [COLS+1:0]  ext [ROWS+2];

    function automatic logic life_rule(input logic self, input logic [3:0] cnt);
        return (cnt == 4'd3) || (self && (cnt == 4'd2));
    endfunction

    assign step_req = step & ~step_q & ~run;
    assign run_req  = run & (per_cnt == CNT_W'(PERIOD - 1));
    assign adv      = step_req | run_req;
    assign extinct  = ~|alive;

    always_comb begin
        for (int r = 0; r < ROWS + 2; r++) begin
            ext[r] = '0;
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                ext[r+1][c+1] = alive[c*ROWS+r];
            end
        end
`ifdef LIFE_TORUS_EN
        for (int c = 0; c < COLS; c++) begin
            ext[0][c+1]      = alive[c*ROWS+ROWS-1];
            ext[ROWS+1][c+1] = alive[c*ROWS];
        end
        for (int r = 0; r < ROWS; r++) begin
            ext[r+1][0]      = alive[(COLS-1)*ROWS+r];
            ext[r+1][COLS+1] = alive[r];
        end
        ext[0][0]           = alive[N-1];
        ext[0][COLS+1]      = alive[ROWS-1];
        ext[ROWS+1][0]      = alive[(COLS-1)*ROWS];
        ext[ROWS+1][COLS+1] = alive[0];
`else
        for (int c = 0; c < COLS; c++) begin
            ext[0][c+1]      = n[c];
            ext[ROWS+1][c+1] = s[c];
        end
        for (int r = 0; r < ROWS; r++) begin
            ext[r+1][0]      = w[r];
            ext[r+1][COLS+1] = e[r];
        end
        ext[0][0]           = nw;
        ext[0][COLS+1]      = ne;
        ext[ROWS+1][0]      = sw;
        ext[ROWS+1][COLS+1] = se;
`endif
    end

    always_comb begin
        logic [3:0] sum;
        sum = '0;
        nxt = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                sum = '0;
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        if (!(dr == 1 && dc == 1)) begin
                            sum = sum + {3'b000, ext[r+dr][c+dc]};
                        end
                    end
                end
                nxt[c*ROWS+r] = life_rule(ext[r+1][c+1], sum);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt <= '0;
        end else if (write_enb || !run || run_req) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // A load wins over a same-cycle generation request, which is simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive     <= '0;
            gen_count <= '0;
            changed   <= 1'b0;
        end else if (write_enb) begin
            alive     <= val;
            gen_count <= '0;
            changed   <= 1'b0;
        end else if (adv) begin
            alive     <= nxt;
            gen_count <= gen_count + 1'b1;
            changed   <= (nxt != alive);
        end
    end

endmodule

// File: tb/tb_life_array_grid.sv
// Self-checking bench for life_array_grid (4x4, PERIOD 8): vector table plus
// hand-written sequences for held step, load/step collision, free-run and mid-run reset.
module tb_life_array_grid;

    localparam int OP_LOAD = 0;
    localparam int OP_STEP = 1;

`ifdef LIFE_TORUS_EN
    localparam logic [15:0] ROW0_NEXT = 16'hBBBB;
`else
    localparam logic [15:0] ROW0_NEXT = 16'h0330;
`endif

    typedef struct {
        int          op;
        logic [15:0] v;
        logic [3:0]  nb;
        logic [15:0] x_alive;
        logic [15:0] x_gen;
        logic        x_chg;
        logic        x_ext;
    } vec_t;

    logic        clk = 0;
    logic        reset;
    logic [15:0] val;
    logic        write_enb;
    logic        step;
    logic        run;
    logic [3:0]  n, s, w, e;
    logic        nw, ne, sw, se;
    logic [15:0] alive;
    logic [15:0] gen_count;
    logic        changed;
    logic        extinct;

    int checks = 0;
    int errors = 0;

    life_array_grid #(.ROWS(4), .COLS(4), .GEN_W(16), .PERIOD(8)) dut (
        .clk(clk), .reset(reset), .val(val), .write_enb(write_enb),
        .step(step), .run(run), .n(n), .s(s), .w(w), .e(e),
        .nw(nw), .ne(ne), .sw(sw), .se(se),
        .alive(alive), .gen_count(gen_count),
        .changed(changed), .extinct(extinct)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] a, input logic [15:0] g,
                             input logic c, input logic x);
        chk({tag, ".alive"},   32'(alive),     32'(a));
        chk({tag, ".gen"},     32'(gen_count), 32'(g));
        chk({tag, ".changed"}, 32'(changed),   32'(c));
        chk({tag, ".extinct"}, 32'(extinct),   32'(x));
    endtask

    task automatic load(input logic [15:0] v);
        val = v;
        write_enb = 1;
        tick();
        write_enb = 0;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{OP_LOAD, 16'h0070, 4'b0000, 16'h0070, 16'd0, 1'b0, 1'b0};
        vecs[1]  = '{OP_STEP, 16'h0000, 4'b0000, 16'h0222, 16'd1, 1'b1, 1'b0};
        vecs[2]  = '{OP_STEP, 16'h0000, 4'b0000, 16'h0070, 16'd2, 1'b1, 1'b0};
        vecs[3]  = '{OP_LOAD, 16'h0660, 4'b0000, 16'h0660, 16'd0, 1'b0, 1'b0};
        vecs[4]  = '{OP_STEP, 16'h0000, 4'b0000, 16'h0660, 16'd1, 1'b0, 1'b0};
        vecs[5]  = '{OP_LOAD, 16'h0001, 4'b0000, 16'h0001, 16'd0, 1'b0, 1'b0};
        vecs[6]  = '{OP_STEP, 16'h0000, 4'b0000, 16'h0000, 16'd1, 1'b1, 1'b1};
        vecs[7]  = '{OP_LOAD, 16'h0000, 4'b0000, 16'h0000, 16'd0, 1'b0, 1'b1};
        vecs[8]  = '{OP_STEP, 16'h0000, 4'b0111, 16'h0010, 16'd1, 1'b1, 1'b0};
        vecs[9]  = '{OP_LOAD, 16'h1111, 4'b0000, 16'h1111, 16'd0, 1'b0, 1'b0};
        vecs[10] = '{OP_STEP, 16'h0000, 4'b0000, ROW0_NEXT, 16'd1, 1'b1, 1'b0};

        reset = 1; val = '0; write_enb = 0; step = 0; run = 0;
        n = '0; s = '0; w = '0; e = '0; nw = 0; ne = 0; sw = 0; se = 0;
        #12;
        chk_state("reset", 16'h0000, 16'd0, 1'b0, 1'b1);
        reset = 0;
        tick();

        for (int i = 0; i < 11; i++) begin
            n = vecs[i].nb;
            if (vecs[i].op == OP_LOAD) begin
                load(vecs[i].v);
                tick();
            end else begin
                step = 1;
                tick();
                step = 0;
                tick();
            end
            chk_state($sformatf("vec%0d", i), vecs[i].x_alive, vecs[i].x_gen,
                      vecs[i].x_chg, vecs[i].x_ext);
            n = '0;
        end

        // Step held high for several cycles is a single generation.
        load(16'h0070);
        step = 1;
        repeat (5) tick();
        chk("hold.alive", 32'(alive), 32'h0222);
        chk("hold.gen", 32'(gen_count), 32'd1);
        step = 0;
        tick();

        // Load and step rise on the same edge: load wins, request dropped.
        step = 1;
        val = 16'h0660;
        write_enb = 1;
        tick();
        write_enb = 0;
        chk("coll.alive", 32'(alive), 32'h0660);
        chk("coll.gen", 32'(gen_count), 32'd0);
        tick();
        chk("coll.gen_after", 32'(gen_count), 32'd0);
        step = 0;
        tick();

        // Free-run: generations at cycles 8, 16, 24; step toggling ignored.
        load(16'h0070);
        run = 1;
        for (int i = 1; i <= 24; i++) begin
            step = i[0];
            tick();
            chk($sformatf("run.gen%0d", i), 32'(gen_count), 32'(i / 8));
        end
        step = 0;
        chk("run.alive", 32'(alive), 32'h0222);
        chk("run.changed", 32'(changed), 32'd1);
        tick();
        run = 0;
        tick();
        chk("run.stop_gen", 32'(gen_count), 32'd3);

        // Asynchronous reset mid-run.
        load(16'h0070);
        run = 1;
        repeat (10) tick();
        chk("rr.gen_pre", 32'(gen_count), 32'd1);
        #2;
        reset = 1;
        #1;
        chk("rr.alive", 32'(alive), 32'h0000);
        chk("rr.gen", 32'(gen_count), 32'd0);
        chk("rr.extinct", 32'(extinct), 32'd1);
        run = 0;
        tick();
        reset = 0;
        load(16'h0070);
        step = 1;
        tick();
        step = 0;
        chk("rr.resume", 32'(alive), 32'h0222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
